// File: rtl/inst_loader.sv
// Instruction loader: receives a little-endian 16-bit word count followed by
// big-endian 32-bit words over a byte stream and strobes each word into the fetcher.
module inst_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        load,
  output logic [31:0] load_inst,
  output logic [31:0] load_addr,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, WORD, PULSE, DONE, ERR
  } state_t;

  state_t      state, next_state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic        accept;
  logic [15:0] full_count;

  assign accept     = in_valid && in_ready;
  // Complete length as it will be once the high byte lands this cycle.
  assign full_count = {in_data, count[7:0]};

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        cpu_hold = 1'b0;
        if (start) next_state = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (accept) next_state = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (accept) begin
          if (full_count == 16'd0)             next_state = DONE;
          else if (32'(full_count) > DEPTH)    next_state = ERR;
          else                                 next_state = WORD;
        end
      end
      WORD: begin
        in_ready = 1'b1;
        if (accept && byte_idx == 2'd3) next_state = PULSE;
      end
      PULSE: begin
        load = 1'b1;
        if (word_idx + 16'd1 == count) next_state = DONE;
        else                           next_state = WORD;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) next_state = LEN_LO;
      end
      ERR: begin
        error = 1'b1;
        if (start) next_state = LEN_LO;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= 16'd0;
      word_idx  <= 16'd0;
      byte_idx  <= 2'd0;
      partial   <= 24'd0;
      load_inst <= 32'd0;
      load_addr <= 32'd0;
    end else begin
      state <= next_state;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            count    <= 16'd0;
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
          end
        end
        LEN_LO: if (accept) count[7:0] <= in_data;
        LEN_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            word_idx    <= 16'd0;
            byte_idx    <= 2'd0;
          end
        end
        WORD: begin
          // Output registers change only here, so they hold between pulses.
          if (accept) begin
            partial  <= {partial[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              load_inst <= {partial, in_data};
              load_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
            end
          end
        end
        PULSE: begin
          word_idx <= word_idx + 16'd1;
          byte_idx <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: byte-level reference model compared every
// cycle, plus directed sessions with hand-computed expectations.
module tb_inst_loader;

  localparam int unsigned DEPTH     = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, load, cpu_hold, done, error;
  logic [31:0] load_inst, load_addr;

  inst_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load(load), .load_inst(load_inst), .load_addr(load_addr),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int cycles  = 0;

  // Reference model: tracks the bytes consumed in the current session.
  bit          mValid = 1'b0;
  bit          mActive, mPulse, mDone, mErr;
  logic [31:0] mInst, mAddr;
  logic [7:0]  mBytes[$];
  int          mWords, mCount, mN;

  logic [31:0] logInst[$];
  logic [31:0] logAddr[$];
  int          lastLoadAt = 0;
  int          doneAt = 0;
  int          firstAt = 0;
  bit          prevDone = 1'b0;
  logic [7:0]  txq[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycles);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit v, input logic [7:0] d);
    @(negedge clk);
    start    = s;
    in_valid = v;
    in_data  = d;
  endtask

  always @(posedge clk) cycles++;

  always @(posedge clk) begin
    if (!rst) begin
      mValid = 1'b1; mActive = 1'b0; mPulse = 1'b0; mDone = 1'b0; mErr = 1'b0;
      mInst = 32'd0; mAddr = 32'd0; mBytes.delete(); mWords = 0; mCount = 0;
    end else if (mValid) begin
      if (mPulse) begin
        mPulse = 1'b0;
        mWords++;
        if (mWords == mCount) begin mActive = 1'b0; mDone = 1'b1; end
      end else if (mActive) begin
        if (in_valid) begin
          mBytes.push_back(in_data);
          mN = mBytes.size();
          if (mN == 2) begin
            mCount = int'(mBytes[1]) * 256 + int'(mBytes[0]);
            if (mCount == 0)                begin mActive = 1'b0; mDone = 1'b1; end
            else if (mCount > int'(DEPTH))  begin mActive = 1'b0; mErr = 1'b1; end
          end else if (mN > 2 && (mN - 2) % 4 == 0) begin
            mInst  = {mBytes[mN-4], mBytes[mN-3], mBytes[mN-2], mBytes[mN-1]};
            mAddr  = BASE_ADDR + 32'(4 * mWords);
            mPulse = 1'b1;
          end
        end
      end else if (start) begin
        mActive = 1'b1; mDone = 1'b0; mErr = 1'b0;
        mBytes.delete(); mWords = 0; mCount = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("in_ready",  32'(in_ready),  32'(mActive && !mPulse));
      checkOutput("load",      32'(load),      32'(mPulse));
      checkOutput("load_inst", load_inst,      mInst);
      checkOutput("load_addr", load_addr,      mAddr);
      checkOutput("cpu_hold",  32'(cpu_hold),  32'(mActive || mPulse || mErr));
      checkOutput("done",      32'(done),      32'(mDone));
      checkOutput("error",     32'(error),     32'(mErr));
      if (load) begin
        logInst.push_back(load_inst);
        logAddr.push_back(load_addr);
        lastLoadAt = cycles;
      end
      if (done && !prevDone) doneAt = cycles;
      prevDone = done;
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit gap, input bit withStart);
    int waited = 0;
    if (gap) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(withStart, 1'b1, b);
    while (!in_ready && waited < 40) begin
      applyStimulus(1'b0, 1'b1, b);
      waited++;
    end
    if (!in_ready) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL handshake_timeout: in_ready got 0 expected 1 for byte %0h", b);
    end
  endtask

  task automatic waitFinish(input int budget);
    int k = 0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    while (!(done || error) && k < budget) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      k++;
    end
    if (!(done || error)) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL session_timeout: done/error got 0 expected 1 after %0d cycles", budget);
    end
  endtask

  // gapMode: 0 none, 1 idle cycle before odd bytes, 2 random idles.
  task automatic runStream(input int gapMode, input int abortAt, input int startAt, input int budget);
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < txq.size(); i++) begin
      if (i == abortAt) begin
        applyStimulus(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        return;
      end
      sendByte(txq[i], (gapMode == 1 && i % 2 == 1) || (gapMode == 2 && $urandom_range(0, 1) == 1),
               i == startAt);
      if (i == 0) firstAt = cycles;
    end
    waitFinish(budget);
  endtask

  task automatic buildStream(input int cnt);
    txq.delete();
    txq.push_back(8'(cnt));
    txq.push_back(8'(cnt >> 8));
    if (cnt > 0 && cnt <= int'(DEPTH))
      for (int i = 0; i < 4 * cnt; i++) txq.push_back(8'($urandom));
  endtask

  task automatic loadReq033Stream();
    txq = '{8'h02, 8'h00, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
  endtask

  initial begin
    int cnt;
    $display("[TB] inst_loader bench starting");
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("reset_cpu_hold",  32'(cpu_hold), 32'd0);
    checkOutput("reset_in_ready",  32'(in_ready), 32'd0);
    checkOutput("reset_load_inst", load_inst,     32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Two-word program with valid held high.
    logInst.delete(); logAddr.delete();
    loadReq033Stream();
    runStream(0, -1, -1, 40);
    checkOutput("seq_done",     32'(done),     32'd1);
    checkOutput("seq_cpu_hold", 32'(cpu_hold), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("seq_nloads",   32'(logInst.size()), 32'd2);
    if (logInst.size() == 2) begin
      checkOutput("seq_inst0", logInst[0], 32'h2408_0005);
      checkOutput("seq_addr0", logAddr[0], 32'h0000_0000);
      checkOutput("seq_inst1", logInst[1], 32'h0000_000C);
      checkOutput("seq_addr1", logAddr[1], 32'h0000_0004);
    end
    checkOutput("seq_done_after_pulse", 32'(doneAt - lastLoadAt), 32'd1);
    checkOutput("seq_latency",          32'(doneAt - firstAt),    32'd12);

    // Same stream, valid toggling; byte 6 is presented during the first pulse.
    logInst.delete(); logAddr.delete();
    loadReq033Stream();
    runStream(1, -1, -1, 40);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("gap_nloads", 32'(logInst.size()), 32'd2);
    if (logInst.size() == 2) begin
      checkOutput("gap_inst0", logInst[0], 32'h2408_0005);
      checkOutput("gap_inst1", logInst[1], 32'h0000_000C);
      checkOutput("gap_addr1", logAddr[1], 32'h0000_0004);
    end

    // Zero-length session.
    logInst.delete(); logAddr.delete();
    txq = '{8'h00, 8'h00};
    runStream(0, -1, -1, 10);
    checkOutput("zero_done",   32'(done),            32'd1);
    checkOutput("zero_nloads", 32'(logInst.size()),  32'd0);

    // Over-length session (1025 words).
    txq = '{8'h01, 8'h04};
    runStream(0, -1, -1, 10);
    checkOutput("over_error",    32'(error),          32'd1);
    checkOutput("over_cpu_hold", 32'(cpu_hold),       32'd1);
    checkOutput("over_in_ready", 32'(in_ready),       32'd0);
    checkOutput("over_nloads",   32'(logInst.size()), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("over_cleared",  32'(error),          32'd0);

    // Reset after two bytes of word 1, then a one-word session.
    txq = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    runStream(0, 4, -1, 40);
    checkOutput("abort_cpu_hold",  32'(cpu_hold), 32'd0);
    checkOutput("abort_load_inst", load_inst,     32'd0);
    checkOutput("abort_load_addr", load_addr,     32'd0);
    logInst.delete(); logAddr.delete();
    txq = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    runStream(0, -1, -1, 20);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("after_abort_nloads", 32'(logInst.size()), 32'd1);
    if (logInst.size() == 1) begin
      checkOutput("after_abort_inst", logInst[0], 32'hDEAD_BEEF);
      checkOutput("after_abort_addr", logAddr[0], 32'h0000_0000);
    end

    // Start during WORD is ignored; start in DONE reopens the length phase.
    loadReq033Stream();
    runStream(0, -1, 4, 40);
    checkOutput("midstart_done", 32'(done), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("restart_done",     32'(done),     32'd0);
    checkOutput("restart_in_ready", 32'(in_ready), 32'd1);

    // Largest legal session.
    logInst.delete(); logAddr.delete();
    buildStream(int'(DEPTH));
    runStream(0, -1, -1, 20);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("full_error",  32'(error),           32'd0);
    checkOutput("full_nloads", 32'(logInst.size()),  32'(DEPTH));
    if (logAddr.size() > 0) checkOutput("full_last_addr", logAddr[$], 32'(4 * (DEPTH - 1)));

    // Randomized sessions, stray bytes between them, occasional aborts and mid-session starts.
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 5))
        0:       cnt = 0;
        1:       cnt = int'(DEPTH) + 1 + int'($urandom_range(0, 300));
        default: cnt = int'($urandom_range(1, 8));
      endcase
      buildStream(cnt);
      runStream(2, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, txq.size() - 1)) : -1,
                ($urandom_range(0, 3) == 0) ? 4 : -1, 60);
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
